// File: rtl/condicionador_botoes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : condicionador_botoes_pkg
//  Description : Shared constants, types and helpers for the button
//                conditioner (button count, default debounce length,
//                press counter ceiling, lowest-index picker).
//  Revision    : 1.0 - initial release
// ============================================================================
package condicionador_botoes_pkg;

   // Number of physical buttons handled by the conditioner
   localparam int N_BOTOES = 8;

   // Default debounce length in clock cycles (1 ms at 50 MHz)
   localparam int DEBOUNCE_CYCLES_PADRAO = 50000;

   // Ceiling of the accepted-press counter
   localparam logic [7:0] c_CONTAGEM_MAX = 8'hFF;

   typedef logic [N_BOTOES-1:0] botoes_t;

   // Keeps only the lowest set bit; the lower index wins simultaneous edges
   function automatic botoes_t menor_indice(input botoes_t v);
      botoes_t r;
      r = '0;
      for (int i = N_BOTOES - 1; i >= 0; i--) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/condicionador_botoes_if.sv
`default_nettype none
// ============================================================================
//  Module      : condicionador_botoes_if
//  Description : Bundle of the conditioner's button-side and game-side
//                signals. The master drives raw buttons and control, the
//                slave (conditioner) returns pulses, levels and press count.
//  Revision    : 1.0 - initial release
// ============================================================================
interface condicionador_botoes_if;
   import condicionador_botoes_pkg::*;

   botoes_t    botoes_brutos;
   logic       habilita;
   logic       limpa_contagem;
   botoes_t    pulsos;
   botoes_t    estado_botoes;
   logic [7:0] contagem_jogadas;

   modport master (
      output botoes_brutos,
      output habilita,
      output limpa_contagem,
      input  pulsos,
      input  estado_botoes,
      input  contagem_jogadas
   );

   modport slave (
      input  botoes_brutos,
      input  habilita,
      input  limpa_contagem,
      output pulsos,
      output estado_botoes,
      output contagem_jogadas
   );

endinterface
`default_nettype wire

// File: rtl/condicionador_botoes_debounce_botao.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_botao
//  Description : One button channel: two-flop synchronizer followed by a
//                saturating run-length debouncer. The debounced level only
//                follows the synchronized input after it has disagreed for
//                DEBOUNCE_CYCLES consecutive cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_botao
   import condicionador_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_bruto,
   output logic      o_nivel
);

   localparam int                 c_LARGURA  = $clog2(DEBOUNCE_CYCLES);
   localparam logic [c_LARGURA-1:0] c_CNT_ULTIMO = c_LARGURA'(DEBOUNCE_CYCLES - 1);

   // A length below 2 leaves a zero-width counter; refuse to elaborate
   generate
      if (DEBOUNCE_CYCLES < 2) begin : g_param_invalido
         $error("debounce_botao: DEBOUNCE_CYCLES must be >= 2");
      end
   endgenerate

   logic                 r_sinc1;
   logic                 r_sinc2;
   logic                 r_nivel;
   logic [c_LARGURA-1:0] r_cnt;

   // Two-flop synchronizer for the asynchronous raw level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sinc1 <= 1'b0;
         r_sinc2 <= 1'b0;
      end else begin
         r_sinc1 <= i_bruto;
         r_sinc2 <= r_sinc1;
      end
   end

   // Count consecutive disagreement; accept the new level on the last count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_nivel <= 1'b0;
         r_cnt   <= '0;
      end else if (r_sinc2 == r_nivel) begin
         r_cnt   <= '0;
      end else if (r_cnt == c_CNT_ULTIMO) begin
         r_nivel <= r_sinc2;
         r_cnt   <= '0;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign o_nivel = r_nivel;

endmodule
`default_nettype wire

// File: rtl/condicionador_botoes.sv
`default_nettype none
// ============================================================================
//  Module      : condicionador_botoes
//  Description : Conditions eight raw push buttons into debounced levels,
//                one-cycle press pulses (lowest index wins, gated by
//                habilita) and a saturating count of accepted presses.
//  Revision    : 1.0 - initial release
// ============================================================================
module condicionador_botoes
   import condicionador_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO
) (
   input  wire logic              clk,
   input  wire logic              rst,
   condicionador_botoes_if.slave  bus
);

   botoes_t    w_nivel;
   botoes_t    w_candidatos;
   botoes_t    w_pulso_prox;
   botoes_t    r_nivel_ant;
   botoes_t    r_pulsos;
   logic [7:0] r_contagem;

   generate
      for (genvar i = 0; i < N_BOTOES; i++) begin : g_botao
         debounce_botao #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_bruto (bus.botoes_brutos[i]),
            .o_nivel (w_nivel[i])
         );
      end
   endgenerate

   // Rising debounced edges only; releases produce nothing
   assign w_candidatos = w_nivel & ~r_nivel_ant;

   // Simultaneous edges are dropped except the lowest index; disabled edges are lost
   assign w_pulso_prox = bus.habilita ? menor_indice(w_candidatos) : '0;

   // Previous debounced level for edge detection, and the registered pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_nivel_ant <= '0;
         r_pulsos    <= '0;
      end else begin
         r_nivel_ant <= w_nivel;
         r_pulsos    <= w_pulso_prox;
      end
   end

   // Accepted-press counter: clear wins, otherwise count up to the ceiling
   always_ff @(posedge clk) begin
      if (rst) begin
         r_contagem <= '0;
      end else if (bus.limpa_contagem) begin
         r_contagem <= '0;
      end else if ((|w_pulso_prox) && (r_contagem != c_CONTAGEM_MAX)) begin
         r_contagem <= r_contagem + 8'd1;
      end
   end

   assign bus.pulsos           = r_pulsos;
   assign bus.estado_botoes    = w_nivel;
   assign bus.contagem_jogadas = r_contagem;

endmodule
`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_condicionador_botoes
//  Description : Randomized and directed stimulus for condicionador_botoes
//                against a behavioural model (delay line, sliding window of
//                synchronized samples, lowest-bit arithmetic).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_condicionador_botoes;
   import condicionador_botoes_pkg::*;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   condicionador_botoes_if bus ();

   condicionador_botoes #(
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vetores = 0;
   int n_erros   = 0;

   // Reference model state
   logic [7:0] q_sinc[$];     // raw values sampled at the last two edges, newest first
   logic [7:0] q_janela[$];   // last D synchronized samples, newest first
   logic [7:0] m_nivel;
   logic [7:0] m_cand;
   logic [7:0] m_pulsos;
   int         m_cont;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_vetores++;
      if (obs !== esp) begin
         n_erros++;
         $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, esp, $time);
      end
   endtask

   task automatic modelo_reset();
      q_sinc   = {};
      q_sinc.push_back(8'h00);
      q_sinc.push_back(8'h00);
      q_janela = {};
      for (int k = 0; k < D; k++) q_janela.push_back(8'h00);
      m_nivel  = 8'h00;
      m_cand   = 8'h00;
      m_pulsos = 8'h00;
      m_cont   = 0;
   endtask

   // Effect of one clock edge given the inputs present before it
   task automatic modelo_passo(input logic [7:0] raw, input logic hab, input logic lim, input logic rs);
      logic [7:0] s;
      logic [7:0] novo;
      logic       todos_diferem;
      if (rs) begin
         modelo_reset();
      end else begin
         // Pulse from the edges seen in the cycle before: keep the lowest set bit
         m_pulsos = hab ? (m_cand & (~m_cand + 8'd1)) : 8'h00;
         if (lim)                                  m_cont = 0;
         else if (m_pulsos != 0 && m_cont < 255)   m_cont = m_cont + 1;
         // Synchronized sample arriving now is the raw value from two edges ago
         s = q_sinc.pop_back();
         q_sinc.push_front(raw);
         q_janela.push_front(s);
         void'(q_janela.pop_back());
         // A level flips once the last D synchronized samples all disagree with it
         novo = m_nivel;
         for (int b = 0; b < 8; b++) begin
            todos_diferem = 1'b1;
            foreach (q_janela[k]) if (q_janela[k][b] == m_nivel[b]) todos_diferem = 1'b0;
            if (todos_diferem) novo[b] = ~m_nivel[b];
         end
         m_cand  = novo & ~m_nivel;
         m_nivel = novo;
      end
   endtask

   // Apply inputs, take one edge, then compare away from the edge
   task automatic ciclo(input logic [7:0] raw, input logic hab, input logic lim, input logic rs);
      bus.botoes_brutos  = raw;
      bus.habilita       = hab;
      bus.limpa_contagem = lim;
      rst                = rs;
      @(posedge clk);
      modelo_passo(raw, hab, lim, rs);
      #1;
      verifica("pulsos",           32'(bus.pulsos),           32'(m_pulsos));
      verifica("estado_botoes",    32'(bus.estado_botoes),    32'(m_nivel));
      verifica("contagem_jogadas", 32'(bus.contagem_jogadas), 32'(m_cont));
   endtask

   task automatic segura(input logic [7:0] raw, input logic hab, input int n);
      for (int k = 0; k < n; k++) ciclo(raw, hab, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] raw;
      logic       hab;
      int         dur;
      logic [7:0] bit_um;

      modelo_reset();

      // Reset state
      ciclo(8'h00, 1'b1, 1'b0, 1'b1);
      ciclo(8'h00, 1'b1, 1'b0, 1'b1);
      verifica("reset_pulsos", 32'(bus.pulsos), 32'h0);
      verifica("reset_contagem", 32'(bus.contagem_jogadas), 32'h0);

      // Single press on bit 0, release
      segura(8'h01, 1'b1, 12);
      segura(8'h00, 1'b1, 10);

      // Short glitch on bit 3 must not be accepted
      segura(8'h08, 1'b1, 3);
      segura(8'h00, 1'b1, 10);

      // Simultaneous bits 1 and 3: only bit 1 pulses
      segura(8'h0A, 1'b1, 10);
      segura(8'h00, 1'b1, 10);

      // Disabled press on bit 5, then enabled press
      segura(8'h20, 1'b0, 10);
      segura(8'h00, 1'b0, 10);
      segura(8'h20, 1'b1, 10);
      segura(8'h00, 1'b1, 10);

      // Reset during a bit-2 debounce with the button held through it
      segura(8'h04, 1'b1, 4);
      ciclo(8'h04, 1'b1, 1'b0, 1'b1);
      segura(8'h04, 1'b1, 12);
      segura(8'h00, 1'b1, 10);

      // Randomized holds, glitches, enable, clear and occasional reset
      for (int n = 0; n < 300; n++) begin
         raw = 8'($urandom) & 8'($urandom);
         hab = ($urandom_range(0, 9) < 8);
         dur = $urandom_range(1, 12);
         for (int k = 0; k < dur; k++)
            ciclo(raw, hab, ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
      end

      // Drive the press counter into saturation
      ciclo(8'h00, 1'b1, 1'b1, 1'b0);
      segura(8'h00, 1'b1, 8);
      for (int n = 0; n < 260; n++) begin
         bit_um = 8'h01 << (n % 8);
         segura(bit_um, 1'b1, 7);
         segura(8'h00, 1'b1, 7);
      end
      verifica("contagem_saturada", 32'(bus.contagem_jogadas), 32'd255);

      // Clear coinciding with an emitted pulse
      segura(8'h10, 1'b1, 6);
      ciclo(8'h10, 1'b1, 1'b1, 1'b0);
      ciclo(8'h10, 1'b1, 1'b1, 1'b0);
      segura(8'h10, 1'b1, 4);
      verifica("contagem_limpa", 32'(bus.contagem_jogadas), 32'd0);
      segura(8'h00, 1'b1, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, meaning clock cycles a synchronized input must differ from the debounced level before being accepted; legal range >= 2.
REQ-002 Port clk  input  1  FPGA main clock; sole clock domain.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port botoes_brutos  input  8  raw asynchronous button levels, 1 = pressed.
REQ-005 Port habilita  input  1  1 = presses accepted; 0 = presses discarded (UC level transition).
REQ-006 Port limpa_contagem  input  1  synchronous clear of contagem_jogadas.
REQ-007 Port pulsos  output  8  one-cycle, at-most-one-hot press pulses feeding the matrix controller's botoes input.
REQ-008 Port estado_botoes  output  8  debounced button levels.
REQ-009 Port contagem_jogadas  output  8  count of accepted presses.

Function
REQ-010 Each bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Per bit, when synchronized value equals debounced level, the counter SHALL clear to 0.
REQ-012 Per bit, when they differ and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-013 Per bit, when they differ and counter == DEBOUNCE_CYCLES-1, the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-014 Counter width SHALL be clog2(DEBOUNCE_CYCLES); counters SHALL never wrap.
REQ-015 A debounced 0->1 transition of bit i SHALL be a candidate edge in the cycle it occurs; 1->0 transitions SHALL produce nothing.
REQ-016 pulsos SHALL be registered: a raw level held steady high yields pulsos[i]=1 during the cycle after clock edge DEBOUNCE_CYCLES+3, counted from the first edge sampling it high.
REQ-017 Each pulse SHALL last exactly one cycle regardless of hold duration.
REQ-018 If several candidate edges occur in the same cycle, only the lowest index SHALL pulse; the others SHALL be discarded, not deferred.
REQ-019 Candidate edges occurring while habilita=0 SHALL be discarded; debouncing SHALL continue unaffected.
REQ-020 contagem_jogadas SHALL increment by 1 on each emitted pulse, saturating at 255.
REQ-021 limpa_contagem=1 SHALL set contagem_jogadas to 0 on the next edge, overriding a simultaneous increment.
REQ-022 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL not change estado_botoes.

Reset
REQ-023 rst=1 SHALL clear synchronizers, counters, estado_botoes, pulsos and contagem_jogadas to 0 on the next clk edge.
REQ-024 A button held through reset deassertion SHALL be treated as a new press: pulse DEBOUNCE_CYCLES+3 edges after the first edge with rst=0.
REQ-025 Reset asserted mid-debounce SHALL abort the debounce with no pulse emitted.

Structure
REQ-026 N_BOTOES (8) and default DEBOUNCE_CYCLES SHALL live in the shared constants include file.
REQ-027 Synchronizer plus debounce counter SHALL be sub-module debounce_botao, instantiated N_BOTOES times; arbitration, edge detection and counting stay in the top.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 botoes_brutos=0x01 held from edge 1 -> pulsos=0x01 only in the cycle after edge 7; estado_botoes[0]=1; contagem_jogadas=1.
REQ-029 Bit 3 high for 3 cycles then low -> pulsos stays 0x00, estado_botoes stays 0x00.
REQ-030 0x0A asserted in the same cycle -> single pulse 0x02; contagem_jogadas=1.
REQ-031 habilita=0 during press of bit 5 -> no pulse, estado_botoes[5]=1; re-press with habilita=1 -> pulse 0x20.
REQ-032 260 accepted presses -> contagem_jogadas=255; limpa_contagem coincident with a pulse -> 0.
REQ-033 rst at edge 5 of a bit-2 press, button held -> no pulse before reset; pulse 0x04 seven edges after rst deasserts.
